// File: rtl/au_div_pkg.sv
// Shared definitions for the arithmetic-unit sequential divider.
//   DIV_WIDTH          operand width the divider cell supports
//   DIV_STEPS          iterations per division (one dividend bit each)
//   DIV_ZERO_QUOTIENT  quotient produced naturally when the divisor is zero
//   state_t            controller state encoding (2-bit)
package au_div_pkg;

  localparam int DIV_WIDTH = 4;
  localparam int DIV_STEPS = 4;

  // With divisor == 0 the cell never borrows, so every quotient bit is 1.
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mux2_1_4bit.sv
// 4-bit 2:1 multiplexer.
//   sel  select (0 -> d0, 1 -> d1)
//   d0   input chosen when sel = 0
//   d1   input chosen when sel = 1
//   y    selected value
module mux2_1_4bit (
  input  logic       sel,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  output logic [3:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/restoring_divider_cell.sv
// One iteration of 4-bit restoring division.
//   partial_rem_in   remainder from the previous iteration
//   dividend_bit     next dividend bit (MSB first)
//   divisor          divisor
//   partial_rem_out  remainder after this iteration
//   quotient_bit     quotient bit produced by this iteration
module restoring_divider_cell (
  input  logic [3:0] partial_rem_in,
  input  logic       dividend_bit,
  input  logic [3:0] divisor,
  output logic [3:0] partial_rem_out,
  output logic       quotient_bit
);

  logic [3:0] shifted;
  logic [3:0] diff;
  logic       borrow;

  // Bring in the next dividend bit. Bit 3 of the incoming remainder is
  // shifted out here, but it still decides the outcome below.
  assign shifted = {partial_rem_in[2:0], dividend_bit};

  subtractor_4bit sub (
    .a      (shifted),
    .b      (divisor),
    .diff   (diff),
    .borrow (borrow)
  );

  // If a 1 was shifted out of the top, the true shifted value is at least 16
  // and is always >= divisor; the 4-bit difference is still exact.
  assign quotient_bit = partial_rem_in[3] | ~borrow;

  mux2_1_4bit restore_mux (
    .sel (quotient_bit),
    .d0  (shifted),
    .d1  (diff),
    .y   (partial_rem_out)
  );

endmodule

// File: rtl/subtractor_4bit.sv
// 4-bit unsigned subtractor.
//   a, b    operands (computes a - b)
//   diff    difference modulo 16
//   borrow  1 when a < b
module subtractor_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] diff,
  output logic       borrow
);

  logic [4:0] full;

  assign full   = {1'b0, a} - {1'b0, b};
  assign diff   = full[3:0];
  assign borrow = full[4];

endmodule

// File: rtl/seq_divider_4bit_ctrl.sv
// Multi-cycle 4-bit unsigned divider controller. Reuses one
// restoring_divider_cell for STEPS cycles, one dividend bit per cycle, MSB
// first. Operands arrive and results leave through valid/ready handshakes.
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid / in_ready       operand handshake (in_ready high only in IDLE)
//   dividend, divisor         unsigned operands, sampled on acceptance
//   out_valid / out_ready     result handshake
//   quotient, remainder       registered result, held until the next result
//   div_by_zero               result was produced with divisor == 0
//   busy                      high while iterating
module seq_divider_4bit_ctrl
  import au_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int STEPS = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  // The shared cell is hard-wired to 4 bits; refuse any other geometry.
  if (WIDTH != DIV_WIDTH || STEPS != DIV_STEPS) begin : g_width_check
    $error("seq_divider_4bit_ctrl supports only WIDTH = STEPS = 4");
  end

  localparam int                 CNT_W     = $clog2(STEPS);
  localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(STEPS - 1);

  state_t             state;
  logic [WIDTH-1:0]   div_r;
  logic [WIDTH-1:0]   dvd_r;
  logic [WIDTH-1:0]   rem_r;
  // Only the low WIDTH-1 quotient bits are ever shifted on into the final
  // quotient, so the top bit of the shift register is not stored.
  logic [WIDTH-2:0]   q_r;
  logic               div_by_zero_r;
  logic [CNT_W-1:0]   step_cnt;

  logic [WIDTH-1:0]   cell_rem;
  logic               cell_qbit;
  logic [WIDTH-1:0]   q_next;

  restoring_divider_cell div_cell (
    .partial_rem_in  (rem_r),
    .dividend_bit    (dvd_r[WIDTH-1]),
    .divisor         (div_r),
    .partial_rem_out (cell_rem),
    .quotient_bit    (cell_qbit)
  );

  assign q_next   = {q_r, cell_qbit};
  assign in_ready = (state == ST_IDLE);
  assign busy     = (state == ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      div_r         <= '0;
      dvd_r         <= '0;
      rem_r         <= '0;
      q_r           <= '0;
      div_by_zero_r <= 1'b0;
      step_cnt      <= '0;
      out_valid     <= 1'b0;
      quotient      <= '0;
      remainder     <= '0;
      div_by_zero   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            div_r         <= divisor;
            dvd_r         <= dividend;
            rem_r         <= '0;
            q_r           <= '0;
            div_by_zero_r <= (divisor == '0);
            step_cnt      <= '0;
            state         <= ST_RUN;
          end
        end

        ST_RUN: begin
          rem_r    <= cell_rem;
          q_r      <= q_next[WIDTH-2:0];
          dvd_r    <= {dvd_r[WIDTH-2:0], 1'b0};
          step_cnt <= step_cnt + 1'b1;
          // Final iteration: publish the values the shift registers would
          // take on this edge so the result appears without an extra cycle.
          if (step_cnt == LAST_STEP) begin
            quotient    <= q_next;
            remainder   <= cell_rem;
            div_by_zero <= div_by_zero_r;
            out_valid   <= 1'b1;
            state       <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_4bit_ctrl.sv
// Self-checking bench for seq_divider_4bit_ctrl: directed table, exhaustive
// sweep, randomized operations against an arithmetic reference model, and
// hand-written backpressure / asynchronous reset sequences.
module tb_seq_divider_4bit_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  seq_divider_4bit_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_q;
    logic [3:0] exp_r;
    logic       exp_dbz;
    int         bp;
    bit         noisy;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  // Reference model: plain unsigned arithmetic; a zero divisor yields the
  // all-ones quotient and the dividend as remainder.
  function automatic logic [8:0] ref_div(input logic [3:0] a, input logic [3:0] b);
    int q;
    int r;
    if (b == 4'd0) return {4'hF, a, 1'b1};
    q = int'(a) / int'(b);
    r = int'(a) % int'(b);
    return {4'(q), 4'(r), 1'b0};
  endfunction

  // One full operation: accept, iterate, optional backpressure, handshake.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] eq, input logic [3:0] er, input logic edbz,
                        input int bp, input bit noisy);
    int waitc;
    int lat;
    waitc = 0;
    while (!in_ready && waitc < 20) begin
      tick();
      waitc++;
    end
    check({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    out_ready = (bp == 0);
    tick();
    // After acceptance the operand pins must not matter.
    in_valid = noisy;
    dividend = 4'($urandom);
    divisor  = 4'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      check({tag, " busy_run"}, 32'(busy), 32'd1);
      check({tag, " in_ready_run"}, 32'(in_ready), 32'd0);
      tick();
      lat++;
      if (noisy) begin
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
      end
    end
    check({tag, " latency"}, 32'(lat), 32'd4);
    check({tag, " quotient"}, 32'(quotient), 32'(eq));
    check({tag, " remainder"}, 32'(remainder), 32'(er));
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edbz));
    check({tag, " busy_done"}, 32'(busy), 32'd0);
    for (int i = 0; i < bp; i++) begin
      out_ready = 1'b0;
      tick();
      check({tag, " held_valid"}, 32'(out_valid), 32'd1);
      check({tag, " held_quotient"}, 32'(quotient), 32'(eq));
      check({tag, " held_remainder"}, 32'(remainder), 32'(er));
      check({tag, " held_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    out_ready = 1'b0;
    check({tag, " valid_dropped"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready_after"}, 32'(in_ready), 32'd1);
    $display("op %s: %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d", tag, a, b, quotient, remainder, div_by_zero, lat);
  endtask

  initial begin
    logic [8:0] m;

    vecs[0] = '{a: 4'd13, b: 4'd3,  exp_q: 4'd4,  exp_r: 4'd1,  exp_dbz: 1'b0, bp: 0,  noisy: 1'b0};
    vecs[1] = '{a: 4'd7,  b: 4'd0,  exp_q: 4'hF,  exp_r: 4'd7,  exp_dbz: 1'b1, bp: 0,  noisy: 1'b0};
    vecs[2] = '{a: 4'd15, b: 4'd4,  exp_q: 4'd3,  exp_r: 4'd3,  exp_dbz: 1'b0, bp: 10, noisy: 1'b0};
    vecs[3] = '{a: 4'd0,  b: 4'd5,  exp_q: 4'd0,  exp_r: 4'd0,  exp_dbz: 1'b0, bp: 1,  noisy: 1'b0};
    vecs[4] = '{a: 4'd15, b: 4'd1,  exp_q: 4'd15, exp_r: 4'd0,  exp_dbz: 1'b0, bp: 0,  noisy: 1'b0};
    vecs[5] = '{a: 4'd1,  b: 4'd15, exp_q: 4'd0,  exp_r: 4'd1,  exp_dbz: 1'b0, bp: 2,  noisy: 1'b0};
    vecs[6] = '{a: 4'd0,  b: 4'd0,  exp_q: 4'hF,  exp_r: 4'd0,  exp_dbz: 1'b1, bp: 0,  noisy: 1'b0};
    vecs[7] = '{a: 4'd8,  b: 4'd8,  exp_q: 4'd1,  exp_r: 4'd0,  exp_dbz: 1'b0, bp: 0,  noisy: 1'b0};
    vecs[8] = '{a: 4'd11, b: 4'd5,  exp_q: 4'd2,  exp_r: 4'd1,  exp_dbz: 1'b0, bp: 3,  noisy: 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 4'd0;
    divisor   = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
    check("reset div_by_zero", 32'(div_by_zero), 32'd0);

    foreach (vecs[i])
      run_op($sformatf("table%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_q,
             vecs[i].exp_r, vecs[i].exp_dbz, vecs[i].bp, vecs[i].noisy);

    // Asynchronous reset in the 2nd RUN cycle; last result (11/5) is still held.
    in_valid = 1'b1;
    dividend = 4'd9;
    divisor  = 4'd2;
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst out_valid", 32'(out_valid), 32'd0);
    check("async_rst busy", 32'(busy), 32'd0);
    check("async_rst in_ready", 32'(in_ready), 32'd1);
    check("async_rst quotient", 32'(quotient), 32'd0);
    check("async_rst remainder", 32'(remainder), 32'd0);
    check("async_rst div_by_zero", 32'(div_by_zero), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("async_rst no_valid", 32'(out_valid), 32'd0);
    end
    $display("op async_rst: 9/2 aborted, no result");

    // Exhaustive sweep, back to back.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        m = ref_div(4'(a), 4'(b));
        run_op($sformatf("exh%0d_%0d", a, b), 4'(a), 4'(b), m[8:5], m[4:1], m[0], 0, 1'b0);
      end
    end

    // Randomized operands, backpressure and input noise.
    for (int k = 0; k < 120; k++) begin
      logic [3:0] ra;
      logic [3:0] rb;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      m  = ref_div(ra, rb);
      run_op($sformatf("rand%0d", k), ra, rb, m[8:5], m[4:1], m[0],
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
